// File: rtl/washing_machine_control.sv
// washing_machine_control: Moore FSM sequencing fill/wash/drain/rinse/spin with a door interlock.
module washing_machine_control (
  input  logic clk,
  input  logic reset,
  input  logic td,
  input  logic tf,
  input  logic tr,
  input  logic ts,
  input  logic tw,
  input  logic door,
  input  logic start,
  output logic agitator,
  output logic motor,
  output logic pump,
  output logic speed,
  output logic water_fill,
  output logic timer_reset
);
  typedef enum logic [2:0] {IDLE, FILL1, WASH, DRAIN1, FILL2, RINSE, DRAIN2, SPIN} state_t;
  state_t state, state_nx;
  logic [4:0] t_q, t_ev;
  assign t_ev = {td, tf, tr, ts, tw} & ~t_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      t_q         <= '0;
      timer_reset <= 1'b0;
    end else begin
      state       <= state_nx;
      t_q         <= {td, tf, tr, ts, tw};
      timer_reset <= (state_nx != state) && (state_nx != IDLE);
    end
  end
  // An open door freezes the sequence; events seen meanwhile are consumed by t_q.
  always_comb begin
    state_nx = state;
    if (!door)
      case (state)
        IDLE:    state_nx = start    ? FILL1  : IDLE;
        FILL1:   state_nx = t_ev[3]  ? WASH   : FILL1;
        WASH:    state_nx = t_ev[0]  ? DRAIN1 : WASH;
        DRAIN1:  state_nx = t_ev[4]  ? FILL2  : DRAIN1;
        FILL2:   state_nx = t_ev[3]  ? RINSE  : FILL2;
        RINSE:   state_nx = t_ev[2]  ? DRAIN2 : RINSE;
        DRAIN2:  state_nx = t_ev[4]  ? SPIN   : DRAIN2;
        default: state_nx = t_ev[1]  ? IDLE   : SPIN;
      endcase
  end
  always_comb begin
    water_fill = !door && (state == FILL1 || state == FILL2);
    agitator   = !door && (state == WASH || state == RINSE);
    motor      = !door && (state == WASH || state == RINSE || state == SPIN);
    pump       = !door && (state == DRAIN1 || state == DRAIN2 || state == SPIN);
    speed      = !door && (state == SPIN);
  end
endmodule

// File: tb/tb_washing_machine_control.sv
// tb_washing_machine_control: directed checks of sequencing, interlock, edge detection and reset.
module tb_washing_machine_control;
  logic clk = 1'b0;
  logic reset, td, tf, tr, ts, tw, door, start;
  logic agitator, motor, pump, speed, water_fill, timer_reset;
  int errs = 0;
  int checks = 0;
  int tr_cnt = 0;
  always #5 clk = ~clk;
  washing_machine_control dut (
    .clk(clk), .reset(reset), .td(td), .tf(tf), .tr(tr), .ts(ts), .tw(tw),
    .door(door), .start(start), .agitator(agitator), .motor(motor), .pump(pump),
    .speed(speed), .water_fill(water_fill), .timer_reset(timer_reset)
  );
  // in = {reset,door,start,tf,tw,td,tr,ts}; exp = {agitator,motor,pump,speed,water_fill,timer_reset}
  task automatic cyc(input logic [7:0] in, input logic [5:0] exp, input string tag);
    logic [5:0] obs;
    {reset, door, start, tf, tw, td, tr, ts} = in;
    @(posedge clk);
    #2;
    obs = {agitator, motor, pump, speed, water_fill, timer_reset};
    if (timer_reset) tr_cnt++;
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    {reset, door, start, tf, tw, td, tr, ts} = 8'b10000000;
    cyc(8'b10000000, 6'b000000, "reset1");
    cyc(8'b11000000, 6'b000000, "reset2");
    cyc(8'b00000000, 6'b000000, "idle");
    cyc(8'b01100000, 6'b000000, "idle_door_start");
    cyc(8'b01100000, 6'b000000, "idle_door_start2");
    cyc(8'b00100000, 6'b000011, "fill1_enter");
    cyc(8'b00000000, 6'b000010, "fill1_hold");
    cyc(8'b00000001, 6'b000010, "fill1_spurious_ts");
    cyc(8'b00100000, 6'b000010, "fill1_start_ignored");
    cyc(8'b00010000, 6'b110001, "tf_held_wash");
    for (int i = 0; i < 4; i++) cyc(8'b00010000, 6'b110000, "tf_held_no_adv");
    cyc(8'b00000000, 6'b110000, "wash_idle");
    cyc(8'b01000000, 6'b000000, "wash_door1");
    cyc(8'b01001000, 6'b000000, "wash_door_tw");
    cyc(8'b01000000, 6'b000000, "wash_door3");
    cyc(8'b00000000, 6'b110000, "wash_resume");
    cyc(8'b00000000, 6'b110000, "wash_resume2");
    cyc(8'b00001000, 6'b001001, "drain1");
    cyc(8'b00000000, 6'b001000, "drain1_hold");
    cyc(8'b00000100, 6'b000011, "fill2");
    cyc(8'b00000000, 6'b000010, "fill2_hold");
    cyc(8'b00010000, 6'b110001, "rinse");
    cyc(8'b00000000, 6'b110000, "rinse_hold");
    cyc(8'b00000010, 6'b001001, "drain2");
    cyc(8'b00000000, 6'b001000, "drain2_hold");
    cyc(8'b00000100, 6'b011101, "spin");
    cyc(8'b00000000, 6'b011100, "spin_hold");
    cyc(8'b10000000, 6'b000000, "reset_mid_spin");
    cyc(8'b00000000, 6'b000000, "after_reset_idle");
    cyc(8'b00000001, 6'b000000, "after_reset_no_resume");
    tr_cnt = 0;
    cyc(8'b00100000, 6'b000011, "r2_fill1");
    cyc(8'b01000000, 6'b000000, "r2_fill1_door");
    cyc(8'b00010000, 6'b110001, "r2_wash_door_close_tf");
    cyc(8'b00001000, 6'b001001, "r2_drain1");
    cyc(8'b00000100, 6'b000011, "r2_fill2");
    cyc(8'b00010000, 6'b110001, "r2_rinse");
    cyc(8'b00000010, 6'b001001, "r2_drain2");
    cyc(8'b00000100, 6'b011101, "r2_spin");
    cyc(8'b00000001, 6'b000000, "r2_idle");
    cyc(8'b00000000, 6'b000000, "r2_idle_hold");
    checks++;
    assert (tr_cnt === 7) else begin
      errs++;
      $error("FAIL timer_reset_pulses: observed=%0d expected=7", tr_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/washing_machine_control.md
WASHING_MACHINE_CONTROL -- requirements
Module: washing_machine_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port td, input, 1 bit: drain-timer done.
REQ-004 SHALL have port tf, input, 1 bit: fill-timer done.
REQ-005 SHALL have port tr, input, 1 bit: rinse-timer done.
REQ-006 SHALL have port ts, input, 1 bit: spin-timer done.
REQ-007 SHALL have port tw, input, 1 bit: wash-timer done.
REQ-008 SHALL have port door, input, 1 bit: 1 = door open.
REQ-009 SHALL have port start, input, 1 bit: cycle start request.
REQ-010 SHALL have port agitator, output, 1 bit: agitator drive.
REQ-011 SHALL have port motor, output, 1 bit: drum motor enable.
REQ-012 SHALL have port pump, output, 1 bit: drain pump enable.
REQ-013 SHALL have port speed, output, 1 bit: 0 = low (agitate), 1 = high (spin).
REQ-014 SHALL have port water_fill, output, 1 bit: inlet valve open.
REQ-015 SHALL have port timer_reset, output, 1 bit: restarts the external phase timer.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, FILL1, WASH, DRAIN1, FILL2, RINSE, DRAIN2, SPIN.
REQ-017 SHALL register td/tf/tr/ts/tw each cycle; a timer event is a rising edge (current 1, previous 0); a level held high SHALL produce only one event.
REQ-018 SHALL follow these transitions, one per clock:
- IDLE -> FILL1 when start=1 and door=0
- FILL1 -tf-> WASH -tw-> DRAIN1 -td-> FILL2 -tf-> RINSE -tr-> DRAIN2 -td-> SPIN -ts-> IDLE
REQ-019 SHALL ignore timer events not belonging to the current state, and ignore start outside IDLE.
REQ-020 SHALL drive outputs (all others 0):
- FILL1/FILL2: water_fill=1
- WASH/RINSE: agitator=1, motor=1, speed=0
- DRAIN1/DRAIN2: pump=1
- SPIN: motor=1, pump=1, speed=1
- IDLE: all 0
REQ-021 SHALL, whenever door=1 in a non-IDLE state, force all actuator outputs to 0, hold the state, and discard timer events (edge registers still update); operation SHALL resume in the same state the cycle after door returns to 0.
REQ-022 SHALL decode outputs combinationally from the state register and door, with no combinational path from timer inputs or start to outputs.
REQ-023 SHALL assert timer_reset for exactly one cycle, in the first cycle after each state transition into a non-IDLE state; it SHALL not assert on door pause/resume.
REQ-024 SHALL give timer events priority over a coincident door close: a state is left only when door=0 in the cycle the event is sampled.

Reset
REQ-025 SHALL on reset=1 at a rising clk edge enter IDLE, clear the timer-edge registers and timer_reset, and drive all outputs 0 the following cycle, regardless of current state or door.
REQ-026 SHALL, after reset, start a new cycle only on a fresh start=1 with door=0. Reset mid-cycle abandons the cycle with no resume.

Verification
REQ-027 Reset then idle: reset=1 for 2 cycles -> all six outputs 0, state IDLE.
REQ-028 Full cycle: start=1 and door=0, then single-cycle pulses tf, tw, td, tf, tr, td, ts -> outputs follow REQ-020 in order FILL1..SPIN, then IDLE with all 0; timer_reset pulses 7 times.
REQ-029 Door interlock: door=1 with start=1 in IDLE -> stays IDLE. In WASH, door=1 for 3 cycles -> agitator=motor=0 and tw pulse ignored; after door=0 -> agitator=motor=1, still WASH.
REQ-030 Spurious or held inputs: ts pulse in FILL1 -> no change. tf held high for 5 cycles in FILL1 -> only FILL1->WASH, no further advance.
REQ-031 Reset mid-SPIN: reset=1 for one cycle -> next cycle IDLE, motor=pump=speed=0.
